regwrite_arbiter: RTL and testbench
===================================

Name: regwrite_arbiter

Overview:
- Owns the single write port of the 32x32 register file in the pipelined CPU.
- Shares that port between two requesters:
  - The WB stage, which cannot be back-pressured except through stall_req.
  - The long-latency multiply/divide unit (MDU), which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a pending-write scoreboard for MDU destinations so the decode stage can detect RAW hazards on rs/rt.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2)
MAX_WAIT, 4, cycles a FIFO head may be denied before stall_req forces it through

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous reset, active-high
wb_we  input  1  WB stage requests a register write this cycle
wb_rd  input  ADDR_W  WB destination register
wb_data  input  DATA_W  WB write data
mdu_valid  input  1  MDU result available
mdu_rd  input  ADDR_W  MDU result destination
mdu_data  input  DATA_W  MDU result data
mdu_ready  output  1  FIFO can accept an MDU result
mdu_issue  input  1  an MDU op with destination mdu_issue_rd is issued this cycle
mdu_issue_rd  input  ADDR_W  destination of the issued MDU op
rs  input  ADDR_W  decode-stage source register 1
rt  input  ADDR_W  decode-stage source register 2
rs_busy  output  1  rs has an outstanding MDU write
rt_busy  output  1  rt has an outstanding MDU write
stall_req  output  1  pipeline must hold WB this cycle; the WB request is not accepted
RegWrite  output  1  register file write enable (registered)
write  output  ADDR_W  register file write index (registered)
writeData  output  DATA_W  register file write data (registered)

Behaviour:
- Reset, applied on any edge with RST=1, including mid-operation:
  - RegWrite=0, write=0, writeData=0.
  - FIFO emptied, wait counter=0, all pending bits cleared.
  - stall_req=0 and mdu_ready=0 while RST=1; mdu_ready=1 from the first cycle after RST falls.
  - In-flight MDU results are discarded.
- MDU FIFO:
  - mdu_ready = !full, decoded from registered state.
  - Push on mdu_valid && mdu_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo FIFO_DEPTH.
  - MDU results never bypass the FIFO: a push at edge t makes the entry eligible in the cycle after t, at the earliest.
- Arbitration, per cycle, evaluated combinationally from registered state plus inputs; exactly one grant or none:
  - 1. If stall_req: the FIFO head wins and WB is ignored.
  - 2. Else if wb_we: WB wins.
  - 3. Else if the FIFO is not empty: the FIFO head wins (pop).
  - 4. Else: idle.
- Output timing:
  - The grant is registered onto RegWrite/write/writeData at the next edge, so write latency from acceptance is 1 cycle.
  - RegWrite=0 on idle cycles; write/writeData hold their last values.
- Register 0:
  - A granted write with rd=0 is consumed (FIFO pops, WB accepted) but RegWrite stays 0.
  - pending[0] is never set.
- Wait counter (width clog2(MAX_WAIT+1)):
  - Clears on reset, on every pop, and while the FIFO is empty.
  - Increments, saturating at MAX_WAIT, on each cycle the FIFO is non-empty and not popped.
  - stall_req = !empty && (wait_cnt == MAX_WAIT), combinational from registered state.
  - A new head after a pop starts at 0.
- Scoreboard (32 bits):
  - mdu_issue sets pending[mdu_issue_rd] (ignored for rd=0).
  - A FIFO pop clears pending[head.rd].
  - Set and clear of the same register in the same cycle: set wins.
  - rs_busy = pending[rs]; rt_busy = pending[rt]; both combinational.
  - A write being granted this cycle does not clear busy until the next edge.
- Simultaneous events:
  - WB and FIFO head target the same rd in one cycle: WB writes first, and the MDU result follows on a later cycle, so the MDU value is the final one.
  - Ordering between MDU results is FIFO order.

Test Plan:
- Reset mid-traffic: FIFO holding 2 entries, pending[5]=1, RST pulsed 1 cycle -> next cycle RegWrite=0, rs_busy(rs=5)=0, mdu_ready=1, no stale write ever appears.
- WB only: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF at edge t -> RegWrite=1, write=3, writeData=0xDEADBEEF in cycle t+1; stall_req stays 0.
- MDU idle port: issue rd=7 (rs=7 -> rs_busy=1), later mdu_valid with 0x12345678 pushed at t -> RegWrite=1, write=7 at t+2; rs_busy=0 from t+2.
- Starvation: FIFO head rd=9 with wb_we held 1 every cycle -> after 4 denied cycles stall_req=1 for exactly 1 cycle, head granted, WB request of that cycle not written; WB write resumes the next cycle.
- Full FIFO: WB continuous, two MDU pushes -> mdu_ready=0; a third mdu_valid is held and accepted only the cycle after the first pop.
- $0 and collision: WB rd=0 -> RegWrite=0; WB rd=4 and FIFO head rd=4 in the same cycle -> WB write, then MDU write on the next grant.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: shares one write port between the WB stage and a
// FIFO-buffered multiply/divide unit, and tracks outstanding MDU destinations for hazard checks.
module regwrite_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic              mdu_issue,
    input  logic [ADDR_W-1:0] mdu_issue_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall_req,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write,
    output logic [DATA_W-1:0] writeData
);

    localparam int IDX_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int NREG   = 1 << ADDR_W;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  fifo_d [FIFO_DEPTH];
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_q, write_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic              empty_s, full_s, stall_s, push_s;
    logic              grant_wb_s, grant_fifo_s;
    logic [ENT_W-1:0]  head_s;
    logic [ADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0] head_data_s;

    // FIFO status and the per-cycle grant decision; the head only competes once it is stored
    always_comb begin
        empty_s      = (wr_ptr_q == rd_ptr_q);
        full_s       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        head_s       = fifo_q[rd_ptr_q[IDX_W-1:0]];
        head_rd_s    = head_s[ENT_W-1:DATA_W];
        head_data_s  = head_s[DATA_W-1:0];
        stall_s      = !empty_s && (wait_cnt_q == WAIT_W'(MAX_WAIT));
        grant_fifo_s = stall_s || (!wb_we && !empty_s);
        grant_wb_s   = wb_we && !stall_s;
        push_s       = mdu_valid && !full_s;
    end

    // Next-state for FIFO, starvation counter, scoreboard and the registered write port
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pending_d    = pending_q;
        regwrite_d   = 1'b0;
        write_d      = write_q;
        write_data_d = write_data_q;

        if (push_s) begin
            fifo_d[wr_ptr_q[IDX_W-1:0]] = {mdu_rd, mdu_data};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (grant_fifo_s) begin
            rd_ptr_d               = rd_ptr_q + PTR_W'(1);
            pending_d[head_rd_s]   = 1'b0;
            regwrite_d             = (head_rd_s != {ADDR_W{1'b0}});
            write_d                = head_rd_s;
            write_data_d           = head_data_s;
        end else if (grant_wb_s) begin
            regwrite_d   = (wb_rd != {ADDR_W{1'b0}});
            write_d      = wb_rd;
            write_data_d = wb_data;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A fresh issue must win over a retiring write to the same register
        if (mdu_issue) begin
            pending_d[mdu_issue_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;

        if (empty_s || grant_fifo_s) begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_q       <= '{default: {ENT_W{1'b0}}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            wait_cnt_q   <= {WAIT_W{1'b0}};
            pending_q    <= {NREG{1'b0}};
            regwrite_q   <= 1'b0;
            write_q      <= {ADDR_W{1'b0}};
            write_data_q <= {DATA_W{1'b0}};
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            pending_q    <= pending_d;
            regwrite_q   <= regwrite_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
        end
    end

    assign mdu_ready = !RST && !full_s;
    assign stall_req = !RST && stall_s;
    assign rs_busy   = pending_q[rs];
    assign rt_busy   = pending_q[rt];
    assign RegWrite  = regwrite_q;
    assign write     = write_q;
    assign writeData = write_data_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scenario bench for regwrite_arbiter: expected writes are queued in grant order and
// matched against every RegWrite pulse; per-scenario checks cover handshake and hazard flags.
module tb_regwrite_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic [4:0]  rs, rt;
    logic        rs_busy, rt_busy, stall_req;
    logic        RegWrite;
    logic [4:0]  write;
    logic [31:0] writeData;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    regwrite_arbiter dut (
        .CLK(CLK), .RST(RST),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .stall_req(stall_req),
        .RegWrite(RegWrite), .write(write), .writeData(writeData)
    );

    always #5 CLK = ~CLK;

    // Every register-file write must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (RegWrite === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", write, writeData);
                n_err++;
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({write, writeData} !== e) begin
                    $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             write, writeData, e[36:32], e[31:0]);
                    n_err++;
                end
            end
        end
    end

    task automatic idle_inputs;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'h0;
        mdu_issue = 1'b0; mdu_issue_rd = 5'd0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle_inputs();
        rs = 5'd0; rt = 5'd0;
        @(negedge CLK);
        n_vec++;
        if ({RegWrite, write, writeData} !== 38'h0) begin
            $display("FAIL reset_outputs: got %h, required 0", {RegWrite, write, writeData}); n_err++;
        end
        n_vec++;
        if ({mdu_ready, stall_req} !== 2'b00) begin
            $display("FAIL reset_ready_stall: got %b, required 00", {mdu_ready, stall_req}); n_err++;
        end
        RST = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (mdu_ready !== 1'b1) begin
            $display("FAIL post_reset_ready: got %b, required 1", mdu_ready); n_err++;
        end
    endtask

    task automatic test_wb_only;
        @(negedge CLK);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        exp_q.push_back({5'd3, 32'hDEAD_BEEF});
        #1;
        n_vec++;
        if (stall_req !== 1'b0) begin
            $display("FAIL wb_stall: got %b, required 0", stall_req); n_err++;
        end
        @(negedge CLK);
        idle_inputs();
        n_vec++;
        if ({RegWrite, write, writeData} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
            $display("FAIL wb_latency: got %b/%0d/%h, required 1/3/deadbeef", RegWrite, write, writeData); n_err++;
        end
    endtask

    task automatic test_mdu_idle;
        @(negedge CLK);
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7; rs = 5'd7;
        #1;
        n_vec++;
        if (rs_busy !== 1'b0) begin
            $display("FAIL busy_before_issue: got %b, required 0", rs_busy); n_err++;
        end
        @(negedge CLK);
        mdu_issue = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234_5678;
        exp_q.push_back({5'd7, 32'h1234_5678});
        #1;
        n_vec++;
        if ({rs_busy, mdu_ready} !== 2'b11) begin
            $display("FAIL busy_after_issue: got %b, required 11", {rs_busy, mdu_ready}); n_err++;
        end
        @(negedge CLK);
        mdu_valid = 1'b0;
        n_vec++;
        if ({RegWrite, rs_busy} !== 2'b01) begin
            $display("FAIL mdu_no_bypass: got %b, required 01", {RegWrite, rs_busy}); n_err++;
        end
        @(negedge CLK);
        n_vec++;
        if ({RegWrite, write, writeData, rs_busy} !== {1'b1, 5'd7, 32'h1234_5678, 1'b0}) begin
            $display("FAIL mdu_write: got %b/%0d/%h busy=%b, required 1/7/12345678 busy=0",
                     RegWrite, write, writeData, rs_busy); n_err++;
        end
    endtask

    task automatic test_starvation;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'hB000_0000 + 32'(k);
            mdu_valid = (k == 0); mdu_rd = 5'd9; mdu_data = 32'h0000_0099;
            if (k == 5) exp_q.push_back({5'd9, 32'h0000_0099});
            else        exp_q.push_back({5'd10, 32'hB000_0000 + 32'(k)});
            #1;
            n_vec++;
            if (stall_req !== (k == 5)) begin
                $display("FAIL starve_stall_c%0d: got %b, required %b", k, stall_req, (k == 5)); n_err++;
            end
        end
        @(negedge CLK);
        idle_inputs();
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_full;
        for (int k = 0; k < 9; k++) begin
            logic exp_ready;
            @(negedge CLK);
            wb_we = (k <= 6); wb_rd = 5'd11; wb_data = 32'hC000_0000 + 32'(k);
            mdu_valid = (k <= 6);
            if (k == 0)      begin mdu_rd = 5'd12; mdu_data = 32'hAAAA_0000; end
            else if (k == 1) begin mdu_rd = 5'd13; mdu_data = 32'hAAAA_0001; end
            else             begin mdu_rd = 5'd14; mdu_data = 32'hAAAA_0002; end
            if (k <= 4 || k == 6) exp_q.push_back({5'd11, 32'hC000_0000 + 32'(k)});
            else if (k == 5)      exp_q.push_back({5'd12, 32'hAAAA_0000});
            else if (k == 7)      exp_q.push_back({5'd13, 32'hAAAA_0001});
            else                  exp_q.push_back({5'd14, 32'hAAAA_0002});
            exp_ready = (k <= 1) || (k == 6);
            #1;
            n_vec++;
            if (stall_req !== (k == 5)) begin
                $display("FAIL full_stall_c%0d: got %b, required %b", k, stall_req, (k == 5)); n_err++;
            end
            if (k <= 6) begin
                n_vec++;
                if (mdu_ready !== exp_ready) begin
                    $display("FAIL full_ready_c%0d: got %b, required %b", k, mdu_ready, exp_ready); n_err++;
                end
            end
        end
        @(negedge CLK);
        idle_inputs();
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_zero_collision;
        @(negedge CLK);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        @(negedge CLK);
        idle_inputs();
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h0000_1234;
        mdu_issue = 1'b1; mdu_issue_rd = 5'd0; rs = 5'd0;
        n_vec++;
        if (RegWrite !== 1'b0) begin
            $display("FAIL wb_r0: got %b, required 0", RegWrite); n_err++;
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_vec++;
        if (rs_busy !== 1'b0) begin
            $display("FAIL r0_pending: got %b, required 0", rs_busy); n_err++;
        end
        @(negedge CLK);
        n_vec++;
        if (RegWrite !== 1'b0) begin
            $display("FAIL mdu_r0: got %b, required 0", RegWrite); n_err++;
        end
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h4444_0001;
        @(negedge CLK);
        mdu_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444_0002;
        exp_q.push_back({5'd4, 32'h4444_0002});
        @(negedge CLK);
        idle_inputs();
        exp_q.push_back({5'd4, 32'h4444_0001});
        n_vec++;
        if ({RegWrite, write, writeData} !== {1'b1, 5'd4, 32'h4444_0002}) begin
            $display("FAIL collide_wb_first: got %b/%0d/%h, required 1/4/44440002", RegWrite, write, writeData); n_err++;
        end
        @(negedge CLK);
        n_vec++;
        if ({RegWrite, write, writeData} !== {1'b1, 5'd4, 32'h4444_0001}) begin
            $display("FAIL collide_mdu_last: got %b/%0d/%h, required 1/4/44440001", RegWrite, write, writeData); n_err++;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        mdu_issue = 1'b1; mdu_issue_rd = 5'd5;
        mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h5555_0000;
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h2000_0000;
        exp_q.push_back({5'd20, 32'h2000_0000});
        @(negedge CLK);
        mdu_issue = 1'b0;
        mdu_rd = 5'd6; mdu_data = 32'h6666_0000;
        wb_data = 32'h2000_0001; rt = 5'd5;
        exp_q.push_back({5'd20, 32'h2000_0001});
        #1;
        n_vec++;
        if ({rt_busy, mdu_ready} !== 2'b11) begin
            $display("FAIL mid_busy_ready: got %b, required 11", {rt_busy, mdu_ready}); n_err++;
        end
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        #1;
        n_vec++;
        if ({mdu_ready, stall_req} !== 2'b00) begin
            $display("FAIL mid_rst_ready_stall: got %b, required 00", {mdu_ready, stall_req}); n_err++;
        end
        @(negedge CLK);
        RST = 1'b0; rs = 5'd5;
        #1;
        n_vec++;
        if ({RegWrite, rs_busy, rt_busy, mdu_ready} !== 4'b0001) begin
            $display("FAIL mid_rst_after: got %b, required 0001", {RegWrite, rs_busy, rt_busy, mdu_ready}); n_err++;
        end
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_mdu_idle();
        test_starvation();
        test_full();
        test_zero_collision();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size()); n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
